async_fifo_rd_stream: RTL

Read-side adapter that sits directly downstream of the asynchronous CDC FIFO, in the `rclk` domain. It drains the FIFO's pop interface (empty flag, get-enable, registered read data with one-cycle latency) and presents a `valid`/`ready` stream to downstream logic. A 2-entry output buffer absorbs the FIFO read latency, so the stream sustains one word per cycle under back-pressure without losing or duplicating words.

---
 rtl/async_fifo_pkg.sv | 36 +++
 rtl/rd_skid_buf.sv | 66 ++++++
 rtl/async_fifo_rd_stream.sv | 95 +++++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared definitions for the read side of the asynchronous CDC FIFO:
//   - occ_e      : output-buffer occupancy encoding (EMPTY / ONE / TWO)
//   - BUF_DEPTH  : number of entries in the read-side skid buffer
//   - STAT_WIDTH : width of the optional delivered-word counter
//   - occ_inc / occ_dec : saturating occupancy step helpers
// -----------------------------------------------------------------------------
package async_fifo_pkg;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   localparam int BUF_DEPTH  = 2;
   localparam int STAT_WIDTH = 32;

   // One more word held; the pop rule never lets this step past TWO.
   function automatic occ_e occ_inc(input occ_e occ);
      case (occ)
         OCC_EMPTY: return OCC_ONE;
         default:   return OCC_TWO;
      endcase
   endfunction

   // One fewer word held; only called while the buffer is non-empty.
   function automatic occ_e occ_dec(input occ_e occ);
      case (occ)
         OCC_TWO: return OCC_ONE;
         default: return OCC_EMPTY;
      endcase
   endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// -----------------------------------------------------------------------------
// rd_skid_buf
// Two-entry ring buffer that absorbs the one-cycle FIFO read latency.
// Ports:
//   rclk        in   read-domain clock
//   PresetFull  in   asynchronous active-high reset
//   push        in   write push_data at the tail this edge
//   push_data   in   DATA_WIDTH word to store
//   pop         in   head word consumed this edge
//   flush       in   synchronous discard of all stored words (wins over push/pop)
//   occ         out  occupancy (EMPTY / ONE / TWO)
//   head_data   out  word at the head of the ring
// -----------------------------------------------------------------------------
module rd_skid_buf
   import async_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  rclk,
   input  logic                  PresetFull,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   input  logic                  flush,
   output occ_e                  occ,
   output logic [DATA_WIDTH-1:0] head_data
);

   logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
   logic                  rd_ptr;
   logic                  wr_ptr;

   // Ring storage and occupancy. A simultaneous push and pop leaves the
   // occupancy alone while both pointers advance, which is what gives one
   // word per cycle. Flush re-aligns the pointers so the ring restarts clean.
   always_ff @(posedge rclk or posedge PresetFull) begin
      if (PresetFull) begin
         occ    <= OCC_EMPTY;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         occ    <= OCC_EMPTY;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   occ <= occ_inc(occ);
            2'b01:   occ <= occ_dec(occ);
            default: occ <= occ;
         endcase
      end
   end

   assign head_data = mem[rd_ptr];

endmodule

// File: rtl/async_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// async_fifo_rd_stream
// Read-side adapter in the rclk domain: drains the CDC FIFO pop interface
// (empty flag, get-enable, one-cycle-latency read data) and presents a
// valid/ready stream. A two-entry skid buffer hides the read latency so the
// stream keeps one word per cycle under back-pressure.
// Ports:
//   rclk           in   read-domain clock
//   PresetFull     in   asynchronous active-high reset
//   i_fifo_empty   in   FIFO empty flag
//   o_fifo_get_en  out  FIFO pop request
//   i_fifo_cmd     in   FIFO read data, valid the cycle after a pop
//   i_flush        in   synchronous discard of buffered and in-flight words
//   o_valid        out  stream valid
//   i_ready        in   downstream accept
//   o_data         out  stream data (buffer head)
//   o_pop_cnt      out  delivered-word count, only with
//                       ASYNC_FIFO_RD_STREAM_STAT_EN defined
// -----------------------------------------------------------------------------
module async_fifo_rd_stream
   import async_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  rclk,
   input  logic                  PresetFull,
   input  logic                  i_fifo_empty,
   output logic                  o_fifo_get_en,
   input  logic [DATA_WIDTH-1:0] i_fifo_cmd,
   input  logic                  i_flush,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data
`ifdef ASYNC_FIFO_RD_STREAM_STAT_EN
   ,
   output logic [STAT_WIDTH-1:0] o_pop_cnt
`endif
);

   occ_e       buf_occ;
   logic       inflight;
   logic       xfer;
   logic [2:0] pending;

   assign o_valid = (buf_occ != OCC_EMPTY);
   assign xfer    = o_valid & i_ready;

   // Words that will be held after this edge if no new pop is issued.
   // Popping only while this is below the buffer depth guarantees the
   // word returning next cycle always has a free slot.
   assign pending = {1'b0, buf_occ} + {2'b00, inflight} - {2'b00, xfer};

   // Reset gating keeps the pop request low while the block is held in
   // reset, so no word is pulled from the FIFO and then lost.
   assign o_fifo_get_en = ~PresetFull & ~i_fifo_empty & ~i_flush &
                          (pending < 3'(BUF_DEPTH));

   // Remembers that a pop was accepted, so the read data arriving next
   // cycle gets captured. Flush forgets it, dropping that word.
   always_ff @(posedge rclk or posedge PresetFull) begin
      if (PresetFull) begin
         inflight <= 1'b0;
      end else if (i_flush) begin
         inflight <= 1'b0;
      end else begin
         inflight <= o_fifo_get_en;
      end
   end

   rd_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .rclk       (rclk),
      .PresetFull (PresetFull),
      .push       (inflight),
      .push_data  (i_fifo_cmd),
      .pop        (xfer),
      .flush      (i_flush),
      .occ        (buf_occ),
      .head_data  (o_data)
   );

`ifdef ASYNC_FIFO_RD_STREAM_STAT_EN
   // Counts every handshake, including one that coincides with a flush;
   // only reset clears it.
   always_ff @(posedge rclk or posedge PresetFull) begin
      if (PresetFull) begin
         o_pop_cnt <= '0;
      end else if (xfer) begin
         o_pop_cnt <= o_pop_cnt + STAT_WIDTH'(1);
      end
   end
`endif

endmodule
